// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall strobes
// derived from the synchronised level and its one-cycle-delayed copy.
module spi_sync_edge #(
   parameter int   STAGES = 2,
   parameter logic INIT   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= {STAGES{INIT}};
         prev  <= INIT;
      end else begin
         chain <= {chain[STAGES-2:0], din};
         prev  <= chain[STAGES-1];
      end
   end

   assign level = chain[STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave front end: oversampled SCLK/CS_N/MOSI/DC, MSB-first byte
// deserialiser, and a one-byte holding register feeding the MISO shifter.
module spi_slave #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       spi_sclk_i,
   input  logic       spi_cs_n_i,
   input  logic       spi_mosi_i,
   input  logic       spi_dc_i,
   output logic       spi_miso_o,
   output logic       spi_byte_vld_o,
   output logic [7:0] spi_byte_data_o,
   output logic       dc_o,
   input  logic       tx_byte_vld_i,
   input  logic [7:0] tx_byte_data_i
);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic cs_lvl, cs_rise, cs_fall;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
      .clk   (clk_i),
      .rst   (rst_i),
      .din   (spi_sclk_i),
      .level (sclk_lvl),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   // cs_n resets to deasserted so that releasing reset never fakes an assertion
   spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
      .clk   (clk_i),
      .rst   (rst_i),
      .din   (spi_cs_n_i),
      .level (cs_lvl),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   logic unused_edges;
   assign unused_edges = sclk_lvl | cs_rise;

   logic [SYNC_STAGES-1:0] mosi_sync, dc_sync;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mosi_sync <= '0;
         dc_sync   <= '0;
      end else begin
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
         dc_sync   <= {dc_sync[SYNC_STAGES-2:0], spi_dc_i};
      end
   end

   logic       mosi, dc;
   logic       cs_act;
   logic [2:0] cnt;
   logic [7:0] rx_sr;
   logic [7:0] tx_sr;
   logic [7:0] hold_data;
   logic       hold_full;
   logic       byte_done;
   logic       byte_stb;
   logic       rx_en, load, shift;

   assign mosi   = mosi_sync[SYNC_STAGES-1];
   assign dc     = dc_sync[SYNC_STAGES-1];
   assign cs_act = ~cs_lvl;

   // CS assertion takes precedence over any SCLK edge seen in the same cycle
   always_comb begin
      rx_en = 1'b0;
      load  = 1'b0;
      shift = 1'b0;
      if (cs_act) begin
         if (cs_fall) begin
            load = 1'b1;
         end else begin
            rx_en = sclk_rise;
            load  = sclk_fall & byte_done;
            shift = sclk_fall & ~byte_done;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt             <= 3'd0;
         rx_sr           <= 8'h00;
         tx_sr           <= 8'h00;
         hold_data       <= 8'h00;
         hold_full       <= 1'b0;
         byte_done       <= 1'b0;
         byte_stb        <= 1'b0;
         spi_byte_vld_o  <= 1'b0;
         spi_byte_data_o <= 8'h00;
         dc_o            <= 1'b0;
      end else begin
         byte_stb       <= 1'b0;
         spi_byte_vld_o <= byte_stb;

         if (!cs_act) begin
            cnt       <= 3'd0;
            rx_sr     <= 8'h00;
            byte_done <= 1'b0;
         end

         if (rx_en) begin
            rx_sr <= {rx_sr[6:0], mosi};
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
               spi_byte_data_o <= {rx_sr[6:0], mosi};
               dc_o            <= dc;
               byte_stb        <= 1'b1;
               byte_done       <= 1'b1;
            end
         end

         if (load) begin
            tx_sr     <= hold_full ? hold_data : IDLE_BYTE;
            hold_full <= 1'b0;
            byte_done <= 1'b0;
         end else if (shift) begin
            tx_sr <= {tx_sr[6:0], 1'b0};
         end

         // a strobe coinciding with a load lands in the holding register, not tx_sr
         if (tx_byte_vld_i) begin
            hold_data <= tx_byte_data_i;
            hold_full <= 1'b1;
         end
      end
   end

   assign spi_miso_o = cs_act & tx_sr[7];

endmodule
